// File: rtl/ddr_ring_wr_sched.sv
// Sample-stream FIFO that cuts the stream into fixed-size DDR3 write bursts.
// Burst addresses advance through a circular PL DDR3 region.
module ddr_ring_wr_sched #(
    parameter int unsigned BURST_WORDS = 256,
    parameter int unsigned FIFO_DEPTH  = 1024,
    parameter logic [31:0] RING_BASE   = 32'h0000_0000,
    parameter logic [31:0] RING_BYTES  = 32'h0100_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        din_valid,
    input  logic [31:0] din_data,
    input  logic        flush,
    input  logic        pl_ddr_busy,
    output logic        pl_ddr_wr_start,
    output logic [31:0] pl_ddr_wr_addr,
    output logic [31:0] pl_ddr_wr_length,
    output logic        pl_ddr_wr_en,
    output logic [31:0] pl_ddr_wr_data,
    input  logic        pl_ddr_wr_finish,
    output logic [31:0] wr_ptr,
    output logic [31:0] burst_cnt,
    output logic [15:0] drop_cnt,
    output logic        overflow,
    output logic        idle
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int CW = $clog2(BURST_WORDS) + 1;
    localparam logic [31:0]   BURST_BYTES = 32'(BURST_WORDS * 4);
    localparam logic [31:0]   RING_END    = RING_BASE + RING_BYTES;
    localparam logic [LW-1:0] BW_L        = LW'(BURST_WORDS);
    localparam logic [LW-1:0] DEPTH_L     = LW'(FIFO_DEPTH);
    localparam logic [CW-1:0] BW_C        = CW'(BURST_WORDS);
    localparam logic [CW-1:0] LAST_C      = CW'(BURST_WORDS - 1);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_WAIT_FIN} state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [31:0]   r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wr_idx;
    logic [AW-1:0] r_rd_idx;
    logic [LW-1:0] r_level;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] r_nfifo;
    logic          r_flush_pend;
    logic          r_fin_seen;
    logic [31:0]   r_addr;
    logic [31:0]   r_data;
    logic [31:0]   r_wr_ptr;
    logic [31:0]   r_burst_cnt;
    logic [15:0]   r_drop_cnt;
    logic          r_overflow;

    logic          w_push;
    logic          w_drop;
    logic          w_go;
    logic          w_flush_empty;
    logic          w_last;
    logic          w_fin_done;
    logic          w_pop;
    logic [CW-1:0] w_nfifo;
    logic [31:0]   w_rd_word;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    function automatic logic [31:0] ring_next(input logic [31:0] p);
        logic [31:0] n;
        n = p + BURST_BYTES;
        return (n == RING_END) ? RING_BASE : n;
    endfunction

    assign w_push        = din_valid & enable & (r_level != DEPTH_L);
    assign w_drop        = din_valid & enable & (r_level == DEPTH_L);
    assign w_go          = (r_state == S_IDLE) & enable & ~pl_ddr_busy &
                           ((r_level >= BW_L) | (r_flush_pend & (r_level != '0)));
    assign w_flush_empty = (r_state == S_IDLE) & enable & ~pl_ddr_busy &
                           r_flush_pend & (r_level == '0);
    assign w_last        = (r_state == S_DATA) & (r_cnt == LAST_C);
    assign w_fin_done    = (r_state == S_WAIT_FIN) & (pl_ddr_wr_finish | r_fin_seen);
    assign w_nfifo       = (r_level >= BW_L) ? BW_C : r_level[CW-1:0];
    assign w_rd_word     = r_mem[r_rd_idx];
    // The first word is fetched as START ends so data is ready on the first en cycle.
    assign w_pop         = ((r_state == S_START) & (w_nfifo != '0)) |
                           ((r_state == S_DATA) & ~w_last & ((r_cnt + CW'(1)) < r_nfifo));

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:     if (w_go) w_state_nxt = S_START;
            S_START:    w_state_nxt = S_DATA;
            S_DATA:     if (w_last) w_state_nxt = S_WAIT_FIN;
            S_WAIT_FIN: if (w_fin_done) w_state_nxt = S_IDLE;
            default:    w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        pl_ddr_wr_start = (r_state == S_START);
        pl_ddr_wr_en    = (r_state == S_DATA);
        idle            = (r_state == S_IDLE) & (r_level == '0);
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_idx] <= din_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_idx     <= '0;
            r_rd_idx     <= '0;
            r_level      <= '0;
            r_cnt        <= '0;
            r_nfifo      <= '0;
            r_flush_pend <= 1'b0;
            r_fin_seen   <= 1'b0;
            r_addr       <= RING_BASE;
            r_data       <= '0;
            r_wr_ptr     <= RING_BASE;
            r_burst_cnt  <= '0;
            r_drop_cnt   <= '0;
            r_overflow   <= 1'b0;
        end else begin
            if (w_push) r_wr_idx <= r_wr_idx + AW'(1);
            if (w_pop)  r_rd_idx <= r_rd_idx + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase

            if (w_drop) begin
                r_drop_cnt <= sat_inc16(r_drop_cnt);
                r_overflow <= 1'b1;
            end

            if (flush)                      r_flush_pend <= 1'b1;
            else if (w_go | w_flush_empty)  r_flush_pend <= 1'b0;

            if (w_go) r_addr <= r_wr_ptr;

            if (r_state == S_START) begin
                r_nfifo <= w_nfifo;
                r_cnt   <= '0;
                r_data  <= (w_nfifo != '0) ? w_rd_word : 32'h0;
            end else if (r_state == S_DATA) begin
                r_cnt  <= w_last ? r_cnt : r_cnt + CW'(1);
                r_data <= w_pop ? w_rd_word : 32'h0;
            end

            // Finish may arrive before the last data word; remember it for WAIT_FIN.
            if (w_fin_done | w_go)
                r_fin_seen <= 1'b0;
            else if (((r_state == S_START) | (r_state == S_DATA)) & pl_ddr_wr_finish)
                r_fin_seen <= 1'b1;

            if (w_fin_done) begin
                r_burst_cnt <= r_burst_cnt + 32'd1;
                r_wr_ptr    <= ring_next(r_wr_ptr);
            end
        end
    end

    assign pl_ddr_wr_addr   = r_addr;
    assign pl_ddr_wr_length = BURST_BYTES;
    assign pl_ddr_wr_data   = r_data;
    assign wr_ptr           = r_wr_ptr;
    assign burst_cnt        = r_burst_cnt;
    assign drop_cnt         = r_drop_cnt;
    assign overflow         = r_overflow;

endmodule

// File: tb/tb_ddr_ring_wr_sched.sv
// Directed and randomized bench for ddr_ring_wr_sched with a queue-based
// reference model of FIFO contents, ring pointer and counters.
module tb_ddr_ring_wr_sched;
    localparam int          BW    = 16;
    localparam int          DEPTH = 32;
    localparam logic [31:0] BASE  = 32'h0000_1000;
    localparam logic [31:0] RBYTES = 32'd128;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        enable = 1'b1;
    logic        din_valid = 1'b0;
    logic [31:0] din_data = '0;
    logic        flush = 1'b0;
    logic        busy = 1'b1;
    logic        start;
    logic [31:0] addr;
    logic [31:0] len;
    logic        en;
    logic [31:0] data;
    logic        finish = 1'b0;
    logic [31:0] wr_ptr;
    logic [31:0] burst_cnt;
    logic [15:0] drop_cnt;
    logic        overflow;
    logic        idle;

    int          n_chk = 0;
    int          n_fail = 0;

    logic [31:0] q[$];
    logic [31:0] m_wr_ptr = BASE;
    logic [31:0] m_burst = 0;
    logic [15:0] m_drop = 0;
    logic        m_ovf = 0;
    logic        m_flush = 0;

    ddr_ring_wr_sched #(
        .BURST_WORDS(BW), .FIFO_DEPTH(DEPTH), .RING_BASE(BASE), .RING_BYTES(RBYTES)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .din_valid(din_valid), .din_data(din_data),
        .flush(flush), .pl_ddr_busy(busy), .pl_ddr_wr_start(start), .pl_ddr_wr_addr(addr),
        .pl_ddr_wr_length(len), .pl_ddr_wr_en(en), .pl_ddr_wr_data(data),
        .pl_ddr_wr_finish(finish), .wr_ptr(wr_ptr), .burst_cnt(burst_cnt),
        .drop_cnt(drop_cnt), .overflow(overflow), .idle(idle)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_status();
        chk("burst_cnt", burst_cnt, m_burst);
        chk("wr_ptr", wr_ptr, m_wr_ptr);
        chk("drop_cnt", 32'(drop_cnt), 32'(m_drop));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        chk("idle", 32'(idle), (q.size() == 0) ? 32'd1 : 32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        q.delete();
        m_wr_ptr = BASE; m_burst = 0; m_drop = 0; m_ovf = 0; m_flush = 0;
        chk("rst_start", 32'(start), 32'd0);
        chk("rst_en", 32'(en), 32'd0);
        chk("rst_data", data, 32'd0);
        chk("rst_addr", addr, BASE);
        check_status();
    endtask

    task automatic push(input logic [31:0] w, input logic accept);
        enable = accept;
        din_valid = 1'b1;
        din_data = w;
        tick();
        din_valid = 1'b0;
        enable = 1'b1;
        if (accept) begin
            if (q.size() < DEPTH) q.push_back(w);
            else begin
                if (m_drop != 16'hFFFF) m_drop++;
                m_ovf = 1'b1;
            end
        end
    endtask

    task automatic do_flush();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        m_flush = 1'b1;
    endtask

    task automatic wait_start(output int lat);
        lat = 0;
        busy = 1'b0;
        for (int k = 0; k < 10 && !start; k++) begin
            tick();
            lat++;
        end
        busy = 1'b1;
        chk("start_latency", 32'(lat), 32'd1);
    endtask

    task automatic do_burst(input int fin_delay);
        logic [31:0] exp_w[BW];
        int n;
        int lat;
        wait_start(lat);
        if (!start) return;
        chk("wr_addr", addr, m_wr_ptr);
        chk("wr_length", len, 32'(BW * 4));
        n = (q.size() < BW) ? q.size() : BW;
        for (int i = 0; i < BW; i++) exp_w[i] = (i < n) ? q.pop_front() : 32'h0;
        m_flush = 1'b0;
        for (int i = 0; i < BW; i++) begin
            tick();
            chk($sformatf("en[%0d]", i), 32'(en), 32'd1);
            chk($sformatf("data[%0d]", i), data, exp_w[i]);
        end
        if (fin_delay == 0) begin
            finish = 1'b1;
            tick();
            finish = 1'b0;
            chk("en_after_last", 32'(en), 32'd0);
            tick();
        end else begin
            for (int d = 0; d < fin_delay; d++) begin
                tick();
                if (d == 0) chk("en_after_last", 32'(en), 32'd0);
            end
            finish = 1'b1;
            tick();
            finish = 1'b0;
        end
        m_burst++;
        m_wr_ptr = m_wr_ptr + 32'(BW * 4);
        if (m_wr_ptr == BASE + RBYTES) m_wr_ptr = BASE;
        check_status();
    endtask

    task automatic drain(input int fin_delay);
        while (q.size() >= BW || (m_flush && q.size() > 0)) do_burst(fin_delay);
    endtask

    initial begin
        int lat;
        int nw;
        tick();
        do_reset();

        // Single full burst, finish two cycles after the last word.
        for (int i = 1; i <= 16; i++) push(32'(i), 1'b1);
        do_burst(2);

        // Three bursts in a two-burst ring: addresses wrap back to the base.
        do_reset();
        for (int b = 0; b < 3; b++) begin
            for (int i = 0; i < 16; i++) push(32'h100 * (b + 1) + 32'(i), 1'b1);
            do_burst(1);
        end
        chk("ring_wr_ptr", wr_ptr, BASE + 32'd64);

        // Partial burst pushed out by flush, padded with zeros.
        for (int i = 0; i < 5; i++) push(32'hA000 + 32'(i), 1'b1);
        do_flush();
        do_burst(0);
        chk("flush_idle", 32'(idle), 32'd1);

        // Busy held: no start until it drops.
        for (int i = 0; i < 16; i++) push(32'hB000 + 32'(i), 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("busy_no_start", 32'(start), 32'd0);
        end
        do_burst(3);

        // Randomized traffic against the model.
        for (int it = 0; it < 12; it++) begin
            nw = $urandom_range(1, 20);
            for (int i = 0; i < nw; i++) push($urandom, ($urandom_range(0, 4) != 0));
            if ($urandom_range(0, 2) == 0 && q.size() > 0) do_flush();
            drain($urandom_range(0, 3));
            check_status();
        end

        // Overflow: 40 pushes into a 32-deep FIFO with busy held.
        do_reset();
        for (int i = 0; i < 40; i++) push(32'h500 + 32'(i), 1'b1);
        chk("ovf_drop_cnt", 32'(drop_cnt), 32'd8);
        chk("ovf_flag", 32'(overflow), 32'd1);
        drain(1);

        // Reset during the fifth data word aborts the burst.
        for (int i = 0; i < 16; i++) push(32'hC000 + 32'(i), 1'b1);
        wait_start(lat);
        for (int i = 0; i < 5; i++) tick();
        chk("fifth_en", 32'(en), 32'd1);
        do_reset();
        tick();
        chk("abort_en", 32'(en), 32'd0);
        for (int i = 0; i < 16; i++) push(32'hD000 + 32'(i), 1'b1);
        do_burst(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
